// File: rtl/vpu_issue_ctrl.sv
// vpu_issue_ctrl: in-order op buffer and single-issue sequencer in front of
// the VPU fixed-latency execution counter. Ops are queued in a small FIFO,
// started one at a time, and delivered on a valid/ready writeback port.
// Optional build macro: VPU_ISSUE_TIMEOUT_EN adds a watchdog in WAIT that
// forces completion after TIMEOUT_CYCLES cycles and flags err_o.
module vpu_issue_ctrl #(
  parameter int OPCODE_WIDTH   = 5,
  parameter int DST_WIDTH      = 5,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    op_valid_i,
  output logic                    op_ready_o,
  input  logic [OPCODE_WIDTH-1:0] op_opcode_i,
  input  logic [DST_WIDTH-1:0]    op_dst_i,
  output logic                    exec_start_o,
  input  logic                    exec_done_i,
  output logic                    wb_valid_o,
  input  logic                    wb_ready_i,
  output logic [OPCODE_WIDTH-1:0] wb_opcode_o,
  output logic [DST_WIDTH-1:0]    wb_dst_o,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = OPCODE_WIDTH + DST_WIDTH;

  // Reject parameter sets the pointer arithmetic cannot support.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("vpu_issue_ctrl: FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("vpu_issue_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, START, WAIT, WB} state_t;

  state_t                  state_reg;
  logic [ENT_W-1:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_reg;
  logic [PTR_W-1:0]        rd_ptr_reg;
  logic [CNT_W-1:0]        count_reg;
  logic [OPCODE_WIDTH-1:0] wb_opcode_reg;
  logic [DST_WIDTH-1:0]    wb_dst_reg;
  logic                    err_reg;

  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    push;
  logic                    pop;
  logic                    timeout_hit;
  logic                    complete;
  logic [OPCODE_WIDTH-1:0] head_opcode;
  logic [DST_WIDTH-1:0]    head_dst;

  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
  assign push       = op_valid_i && !fifo_full;
  // A real done always wins over the watchdog, so both count as completion.
  assign complete   = (state_reg == WAIT) && (exec_done_i || timeout_hit);
  assign pop        = complete;
  assign {head_opcode, head_dst} = mem[rd_ptr_reg];

  // Op storage: data only, no reset needed since occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {op_opcode_i, op_dst_i};
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

`ifdef VPU_ISSUE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wdog_reg;

  // Watchdog: held at zero outside WAIT so every WAIT entry starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_reg <= '0;
    end else if (state_reg != WAIT) begin
      wdog_reg <= '0;
    end else begin
      wdog_reg <= wdog_reg + WD_W'(1);
    end
  end

  // Fires in the WAIT cycle in which the count reaches TIMEOUT_CYCLES.
  assign timeout_hit = (state_reg == WAIT) && (wdog_reg == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Issue sequencer with the writeback holding registers and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      wb_opcode_reg <= '0;
      wb_dst_reg    <= '0;
      err_reg       <= 1'b0;
    end else begin
      if (exec_done_i && state_reg != WAIT) err_reg <= 1'b1;
      if (timeout_hit && !exec_done_i)      err_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (!fifo_empty) state_reg <= START;
        end
        START: begin
          state_reg <= WAIT;
        end
        WAIT: begin
          if (complete) begin
            wb_opcode_reg <= head_opcode;
            wb_dst_reg    <= head_dst;
            state_reg     <= WB;
          end
        end
        WB: begin
          if (wb_ready_i) state_reg <= (!fifo_empty || push) ? START : IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign op_ready_o   = !fifo_full;
  assign exec_start_o = (state_reg == START);
  assign wb_valid_o   = (state_reg == WB);
  assign wb_opcode_o  = wb_opcode_reg;
  assign wb_dst_o     = wb_dst_reg;
  assign busy_o       = !fifo_empty || (state_reg != IDLE);
  assign err_o        = err_reg;

endmodule

// File: tb/tb_vpu_issue_ctrl.sv
// Testbench for vpu_issue_ctrl: a behavioural latency counter answers each
// start pulse, a scoreboard queue holds accepted ops, and a writeback monitor
// pops and compares on every handshake. Timeout checks run only when
// VPU_ISSUE_TIMEOUT_EN is defined.
module tb_vpu_issue_ctrl;

  logic       clk;
  logic       rst_n;
  logic       op_valid_i;
  logic       op_ready_o;
  logic [4:0] op_opcode_i;
  logic [4:0] op_dst_i;
  logic       exec_start_o;
  logic       exec_done_i;
  logic       wb_valid_o;
  logic       wb_ready_i;
  logic [4:0] wb_opcode_o;
  logic [4:0] wb_dst_o;
  logic       busy_o;
  logic       err_o;

  logic       ctr_done;
  logic       man_done;
  logic       ctr_en;
  int         done_lat;
  int         ctr_left;

  int         n_checks;
  int         n_fail;
  logic [9:0] sb[$];

  typedef struct {
    logic [4:0] opc;
    logic [4:0] dst;
    int         lat;
    int         hold;
    int         exp_wb;
  } vec_t;
  vec_t vecs[5];

  assign exec_done_i = ctr_done | man_done;

  vpu_issue_ctrl #(
    .OPCODE_WIDTH  (5),
    .DST_WIDTH     (5),
    .FIFO_DEPTH    (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_valid_i  (op_valid_i),
    .op_ready_o  (op_ready_o),
    .op_opcode_i (op_opcode_i),
    .op_dst_i    (op_dst_i),
    .exec_start_o(exec_start_o),
    .exec_done_i (exec_done_i),
    .wb_valid_o  (wb_valid_o),
    .wb_ready_i  (wb_ready_i),
    .wb_opcode_o (wb_opcode_o),
    .wb_dst_o    (wb_dst_o),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds op_valid until accepted; leaves op_valid asserted on return.
  task automatic push_op(input logic [4:0] opc, input logic [4:0] dst);
    int n;
    n = 0;
    op_valid_i  = 1'b1;
    op_opcode_i = opc;
    op_dst_i    = dst;
    @(negedge clk);
    while (!op_ready_o && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!op_ready_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: op_ready_o stayed %0b, required 1", op_ready_o);
    end else begin
      sb.push_back({opc, dst});
    end
    tick();
  endtask

  task automatic wait_wb(input string name);
    int n;
    n = 0;
    while (!wb_valid_o && n < 100) begin
      tick();
      n++;
    end
    chk(name, 32'(wb_valid_o), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy_o && n < 200) begin
      tick();
      n++;
    end
    chk(name, 32'(busy_o), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    sb.delete();
  endtask

  // Latency counter model: done pulses done_lat cycles after the start pulse.
  initial begin
    ctr_done = 1'b0;
    ctr_left = 0;
    forever begin
      tick();
      ctr_done = 1'b0;
      if (!rst_n) begin
        ctr_left = 0;
      end else if (ctr_en) begin
        if (ctr_left > 0) begin
          ctr_left--;
          if (ctr_left == 0) ctr_done = 1'b1;
        end
        if (exec_start_o) ctr_left = done_lat;
      end
    end
  end

  // Writeback monitor: scoreboard compare on handshake, stability under stall.
  initial begin
    logic       pv;
    logic [9:0] pdata;
    logic [9:0] exp;
    pv = 1'b0;
    pdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (pv) begin
          chk("wb_hold_valid", 32'(wb_valid_o), 32'd1);
          chk("wb_hold_data", 32'({wb_opcode_o, wb_dst_o}), 32'(pdata));
        end
        if (wb_valid_o) chk("no_start_in_wb", 32'(exec_start_o), 32'd0);
        if (wb_valid_o && wb_ready_i) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wb_unexpected: got op %0h, required no writeback", {wb_opcode_o, wb_dst_o});
          end else begin
            exp = sb.pop_front();
            chk("wb_data", 32'({wb_opcode_o, wb_dst_o}), 32'(exp));
          end
        end
        pv    = wb_valid_o && !wb_ready_i;
        pdata = {wb_opcode_o, wb_dst_o};
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    int cyc;
    int seen;
    vecs[0] = '{5'h03, 5'h07, 4, 0, 7};
    vecs[1] = '{5'h1F, 5'h00, 1, 3, 4};
    vecs[2] = '{5'h00, 5'h1F, 2, 10, 5};
    vecs[3] = '{5'h15, 5'h0A, 7, 1, 10};
    vecs[4] = '{5'h0A, 5'h15, 1, 0, 4};

    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    op_valid_i  = 1'b0;
    op_opcode_i = '0;
    op_dst_i    = '0;
    wb_ready_i  = 1'b0;
    man_done    = 1'b0;
    ctr_en      = 1'b1;
    done_lat    = 4;

    // Reset state
    #23;
    chk("rst_op_ready", 32'(op_ready_o), 32'd1);
    chk("rst_start", 32'(exec_start_o), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    chk("rst_wb_data", 32'({wb_opcode_o, wb_dst_o}), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Table: single ops with varied done latency and writeback stall
    for (int i = 0; i < 5; i++) begin
      done_lat   = vecs[i].lat;
      wb_ready_i = 1'b0;
      push_op(vecs[i].opc, vecs[i].dst);
      op_valid_i = 1'b0;
      cyc = 1;
      chk("busy_after_push", 32'(busy_o), 32'd1);
      tick();
      cyc++;
      chk("start_cycle2", 32'(exec_start_o), 32'd1);
      tick();
      cyc++;
      chk("start_one_cycle", 32'(exec_start_o), 32'd0);
      while (!wb_valid_o && cyc < 40) begin
        tick();
        cyc++;
      end
      chk("wb_latency", 32'(cyc), 32'(vecs[i].exp_wb));
      for (int h = 0; h < vecs[i].hold; h++) tick();
      wb_ready_i = 1'b1;
      tick();
      wb_ready_i = 1'b0;
      chk("wb_valid_drop", 32'(wb_valid_o), 32'd0);
      chk("busy_clear", 32'(busy_o), 32'd0);
      chk("err_clean", 32'(err_o), 32'd0);
      $display("vec %0d: op %0h/%0h lat %0d hold %0d wb at cycle %0d", i,
               vecs[i].opc, vecs[i].dst, vecs[i].lat, vecs[i].hold, cyc);
    end

    // Backpressure: 10 stalled cycles in WB, then next start right after release
    done_lat = 2;
    push_op(5'h04, 5'h11);
    push_op(5'h05, 5'h12);
    op_valid_i = 1'b0;
    wait_wb("bp_wb_first");
    for (int h = 0; h < 10; h++) begin
      tick();
      chk("bp_valid_held", 32'(wb_valid_o), 32'd1);
      chk("bp_no_start", 32'(exec_start_o), 32'd0);
    end
    wb_ready_i = 1'b1;
    tick();
    wb_ready_i = 1'b0;
    chk("bp_start_after_release", 32'(exec_start_o), 32'd1);
    wait_wb("bp_wb_second");
    wb_ready_i = 1'b1;
    tick();
    wb_ready_i = 1'b0;
    wait_idle("bp_idle");
    $display("backpressure sequence done");

    // Fill and order: six back-to-back pushes against a stalled writeback
    done_lat = 3;
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          push_op(5'(k + 8), 5'(20 - k));
          if (k == 3) chk("full_after_4", 32'(op_ready_o), 32'd0);
        end
        op_valid_i = 1'b0;
      end
      begin
        repeat (12) tick();
        wb_ready_i = 1'b1;
      end
    join
    seen = 0;
    while (sb.size() != 0 && seen < 200) begin
      tick();
      seen++;
    end
    chk("fill_drain", 32'(sb.size()), 32'd0);
    wait_idle("fill_idle");
    wb_ready_i = 1'b0;
    chk("fill_ready_back", 32'(op_ready_o), 32'd1);
    $display("fill and order sequence done");

    // Stray done in IDLE: sticky error, sequencing unaffected
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    chk("stray_err", 32'(err_o), 32'd1);
    chk("stray_busy", 32'(busy_o), 32'd0);
    chk("stray_ready", 32'(op_ready_o), 32'd1);
    done_lat = 2;
    push_op(5'h19, 5'h06);
    op_valid_i = 1'b0;
    wait_wb("stray_wb");
    wb_ready_i = 1'b1;
    tick();
    wb_ready_i = 1'b0;
    chk("stray_err_sticky", 32'(err_o), 32'd1);
    wait_idle("stray_idle");
    $display("stray done sequence done");

    // Reset while an op waits in WAIT with one more buffered
    done_lat = 20;
    push_op(5'h0C, 5'h0D);
    push_op(5'h0E, 5'h0F);
    op_valid_i = 1'b0;
    seen = 0;
    while (!exec_start_o && seen < 20) begin
      tick();
      seen++;
    end
    chk("rw_start_seen", 32'(exec_start_o), 32'd1);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rw_busy", 32'(busy_o), 32'd0);
    chk("rw_ready", 32'(op_ready_o), 32'd1);
    chk("rw_err", 32'(err_o), 32'd0);
    chk("rw_wb_valid", 32'(wb_valid_o), 32'd0);
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    seen = 0;
    wb_ready_i = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (wb_valid_o || exec_start_o) seen++;
    end
    wb_ready_i = 1'b0;
    chk("rw_no_activity", 32'(seen), 32'd0);
    $display("reset mid-wait sequence done");

`ifdef VPU_ISSUE_TIMEOUT_EN
    // Watchdog: forced completion, then done coinciding with the timeout
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      ctr_en = 1'b0;
      push_op(5'h11, 5'h02);
      op_valid_i = 1'b0;
      cyc = 1;
      while (!wb_valid_o && cyc < 40) begin
        man_done = (pass == 1) && (cyc == 10);
        tick();
        man_done = 1'b0;
        cyc++;
      end
      chk("to_wb_cycle", 32'(cyc), 32'd11);
      chk("to_err", 32'(err_o), (pass == 0) ? 32'd1 : 32'd0);
      wb_ready_i = 1'b1;
      tick();
      wb_ready_i = 1'b0;
      chk("to_drained", 32'(sb.size()), 32'd0);
      ctr_en = 1'b1;
      $display("timeout pass %0d: wb at cycle %0d err %0b", pass, cyc, err_o);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
